shift_register_feeder: RTL

- Parallel-to-serial transmitter that drives a shift_register.
- Accepts one SIZE-element word over a valid/ready handshake and emits its elements one per handshake on a DATA_WIDTH stream.
- The stream is consumed by the shift_register's shift_in port in the convolver datapath.
- Output is registered, holds stable under backpressure, and reloads back-to-back with no bubble cycle.

---
 rtl/convolver_pkg.sv | 33 +++
 rtl/shift_register_feeder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/convolver_pkg.sv
// rtl/convolver_pkg.sv - shared constants, state encoding and helpers for the convolver datapath
//
// Purpose : Default element geometry shared by shift_register_feeder and
//           shift_register, the feeder FSM state encoding, and a constant
//           clog2 helper for sizing index registers.
// Ports   : none (package)

package convolver_pkg;

    // Default geometry shared with shift_register
    localparam int DEFAULT_SIZE        = 3;
    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_COUNT_WIDTH = 16;

    // Feeder FSM states
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } feeder_state_t;

    // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : convolver_pkg

// File: rtl/shift_register_feeder.sv
// rtl/shift_register_feeder.sv - parallel-to-serial feeder for the convolver shift_register
//
// Purpose : Accepts one SIZE-element word over a valid/ready handshake and
//           streams its elements, element 0 first, one per handshake on a
//           DATA_WIDTH registered stream. The last element of a word can be
//           retired on the same edge a new word is loaded, so back-to-back
//           words stream with no bubble.
// Ports   :
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   load_data    in   SIZE*DATA_WIDTH parallel word, element i at [i*DW +: DW]
//   load_valid   in   load_data valid
//   load_ready   out  feeder accepts a word this cycle (combinational)
//   shift_out    out  current element (registered)
//   shift_valid  out  shift_out valid
//   shift_ready  in   downstream accepts shift_out this cycle
//   shift_last   out  shift_out is element SIZE-1 of its word
//   words_sent   out  count of fully transmitted words, wraps

module shift_register_feeder
    import convolver_pkg::*;
#(
    parameter int SIZE        = DEFAULT_SIZE,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE*DATA_WIDTH-1:0]   load_data,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic [DATA_WIDTH-1:0]        shift_out,
    output logic                         shift_valid,
    input  logic                         shift_ready,
    output logic                         shift_last,
    output logic [COUNT_WIDTH-1:0]       words_sent
);

    // Index register is at least one bit wide even for degenerate sizes
    localparam int IW = (clog2(SIZE) < 1) ? 1 : clog2(SIZE);
    localparam logic [IW-1:0] LAST_INDEX = IW'(SIZE - 1);

    feeder_state_t               r_state;
    logic [IW-1:0]               r_index;
    logic [SIZE*DATA_WIDTH-1:0]  r_word;
    logic [DATA_WIDTH-1:0]       r_shift_out;
    logic                        r_shift_valid;
    logic                        r_shift_last;
    logic [COUNT_WIDTH-1:0]      r_words_sent;

    logic                        w_load_ready;
    logic                        w_load_fire;
    logic                        w_shift_fire;
    logic                        w_at_last;
    logic [IW-1:0]               w_next_index;
    logic [DATA_WIDTH-1:0]       w_next_elem;
    logic [DATA_WIDTH-1:0]       w_first_elem;

    // Reload is allowed while the final element is being accepted; gating
    // with reset keeps load_ready low for the whole time reset is held.
    assign w_load_ready = reset &&
                          ((r_state == IDLE) || (r_shift_last && shift_ready));
    assign w_load_fire  = load_valid && w_load_ready;
    assign w_shift_fire = r_shift_valid && shift_ready;
    assign w_at_last    = (r_index == LAST_INDEX);
    assign w_next_index = r_index + 1'b1;
    assign w_first_elem = load_data[DATA_WIDTH-1:0];

    // Element mux for the next element of the held word
    always_comb begin
        w_next_elem = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (w_next_index == IW'(i)) begin
                w_next_elem = r_word[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_index       <= '0;
            r_word        <= '0;
            r_shift_out   <= '0;
            r_shift_valid <= 1'b0;
            r_shift_last  <= 1'b0;
            r_words_sent  <= '0;
        end else begin
            // A word counts only once its final element has been accepted
            if (w_shift_fire && w_at_last) begin
                r_words_sent <= r_words_sent + 1'b1;
            end

            if (w_load_fire) begin
                // Covers both the idle load and the pipelined reload
                r_word        <= load_data;
                r_index       <= '0;
                r_state       <= SEND;
                r_shift_out   <= w_first_elem;
                r_shift_valid <= 1'b1;
                r_shift_last  <= (SIZE == 1);
            end else if (w_shift_fire) begin
                if (w_at_last) begin
                    // shift_out intentionally keeps its last value
                    r_state       <= IDLE;
                    r_shift_valid <= 1'b0;
                    r_shift_last  <= 1'b0;
                end else begin
                    r_index      <= w_next_index;
                    r_shift_out  <= w_next_elem;
                    r_shift_last <= (w_next_index == LAST_INDEX);
                end
            end
        end
    end

    assign load_ready  = w_load_ready;
    assign shift_out   = r_shift_out;
    assign shift_valid = r_shift_valid;
    assign shift_last  = r_shift_last;
    assign words_sent  = r_words_sent;

endmodule : shift_register_feeder
